input_window_buffer: RTL
========================

INPUT_WINDOW_BUFFER -- requirements
Module: input_window_buffer

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 8, bits per channel sample.
REQ-002 SHALL have parameter NUM_CHANNEL, default 3, channels packed per entry.
REQ-003 SHALL have parameter NUM_RDATA, default 3, entries returned per read window (1..FF_DEPTH).
REQ-004 SHALL have parameter FF_DEPTH, default 16, entry capacity; SHALL equal 2**FF_ADDR_WIDTH.
REQ-005 SHALL have parameter FF_ADDR_WIDTH, default 4, pointer width.
REQ-006 SHALL have derived parameter DAT_WIDTH = BIT_WIDTH*NUM_CHANNEL, entry width.
REQ-007 SHALL have port clk  input  1  single clock, all logic on its rising edge.
REQ-008 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-009 SHALL have port i_data  input  DAT_WIDTH  write entry, channel c at bits [c*BIT_WIDTH +: BIT_WIDTH].
REQ-010 SHALL have port i_data_vld  input  1  write request.
REQ-011 SHALL have port i_data_req  input  1  window read request.
REQ-012 SHALL have port i_stride  input  FF_ADDR_WIDTH+1  entries popped per accepted read; 0 = peek.
REQ-013 SHALL have port i_err_clr  input  1  clears sticky error flags.
REQ-014 SHALL have port o_data  output  DAT_WIDTH*NUM_RDATA  window, slot k at bits [k*DAT_WIDTH +: DAT_WIDTH].
REQ-015 SHALL have port o_data_vld  output  1  o_data valid, one-cycle pulse per accepted read.
REQ-016 SHALL have port data_counter  output  FF_ADDR_WIDTH+1  stored entry count, 0..FF_DEPTH.
REQ-017 SHALL have ports o_empty, o_full, o_rd_avail  output  1 each  count==0, count==FF_DEPTH, count>=NUM_RDATA.
REQ-018 SHALL have ports o_err_ovf, o_err_udf  output  1 each  sticky overflow / underflow flags.

Function
REQ-019 Write SHALL be accepted iff i_data_vld=1 and pre-edge count<FF_DEPTH; i_data stored at wr_ptr, wr_ptr increments modulo FF_DEPTH.
REQ-020 Read SHALL be accepted iff i_data_req=1 and pre-edge count>=NUM_RDATA.
REQ-021 Accepted read SHALL register slot k = entry at (rd_ptr+k) mod FF_DEPTH, k=0..NUM_RDATA-1, and assert o_data_vld exactly one cycle after the request edge (latency 1).
REQ-022 Accepted read SHALL advance rd_ptr by pop = min(i_stride, NUM_RDATA) modulo FF_DEPTH; i_stride=0 leaves rd_ptr and count unchanged.
REQ-023 Count SHALL update as count + wr_acc - pop in one edge; simultaneous write and read both proceed per REQ-019/020 using pre-edge count.
REQ-024 Entry written at edge N SHALL be readable by a request sampled at edge N+1, not N.
REQ-025 When full, simultaneous write+pop SHALL reject the write (no bypass); o_err_ovf SHALL set.
REQ-026 Rejected read SHALL set o_err_udf, keep o_data_vld=0, hold o_data at prior value, leave pointers unchanged.
REQ-027 Error flags SHALL clear on i_err_clr=1; a set event in the same cycle SHALL win.
REQ-028 Status outputs SHALL be registered or derived from registered count only; no combinational path from inputs.
REQ-029 Pointer and count wrap SHALL be seamless across FF_DEPTH boundary, including windows straddling entry FF_DEPTH-1 to 0.

Reset
REQ-030 With rst=1 at an edge, next cycle SHALL show: wr_ptr=rd_ptr=0, data_counter=0, o_empty=1, o_full=0, o_rd_avail=0, o_data_vld=0, o_data=0, o_err_ovf=o_err_udf=0.
REQ-031 rst SHALL override all same-cycle writes/reads; mid-operation reset discards contents and any in-flight o_data_vld.
REQ-032 Storage array need not be reset; its contents SHALL never be observable before being written.

Verification
REQ-033 Defaults: write 0x010101,0x020202,0x030303; read stride 1 -> next cycle o_data={0x030303,0x020202,0x010101}, o_data_vld=1, data_counter=2.
REQ-034 Fill 16 entries, then write+read(stride 3) same cycle -> write rejected, o_err_ovf=1, data_counter=13.
REQ-035 Count=2, read request -> o_data_vld stays 0, o_err_udf=1, o_data unchanged; i_err_clr -> flag 0 next cycle.
REQ-036 Peek (i_stride=0) twice on 5 entries -> identical windows both cycles, data_counter=5; i_stride=7 -> pop clamped to 3, count=2.
REQ-037 Stream 40 entries with stride-1 reads interleaved -> windows straddling index 15->0 correct, no flags set.
REQ-038 Assert rst while count=9 and read in flight -> next cycle all outputs per REQ-030, o_data_vld=0.

Source files
------------

// File: rtl/input_window_buffer.sv
`default_nettype none
// ============================================================================
// Module      : input_window_buffer
// Description : Circular entry buffer returning a sliding window of
//               NUM_RDATA consecutive entries per accepted read request.
//               Each read pops a programmable stride of 0 (peek) up to
//               NUM_RDATA entries. Overflow and underflow are reported
//               through sticky flags.
// Revision    : 1.0 - initial release
// ============================================================================
module input_window_buffer #(
  parameter int BIT_WIDTH     = 8,
  parameter int NUM_CHANNEL   = 3,
  parameter int NUM_RDATA     = 3,
  parameter int FF_DEPTH      = 16,
  parameter int FF_ADDR_WIDTH = 4,
  parameter int DAT_WIDTH     = BIT_WIDTH * NUM_CHANNEL
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DAT_WIDTH-1:0]           i_data,
  input  logic                           i_data_vld,
  input  logic                           i_data_req,
  input  logic [FF_ADDR_WIDTH:0]         i_stride,
  input  logic                           i_err_clr,
  output logic [DAT_WIDTH*NUM_RDATA-1:0] o_data,
  output logic                           o_data_vld,
  output logic [FF_ADDR_WIDTH:0]         data_counter,
  output logic                           o_empty,
  output logic                           o_full,
  output logic                           o_rd_avail,
  output logic                           o_err_ovf,
  output logic                           o_err_udf
);

  // Depth and window size expressed at count width for direct comparison.
  localparam logic [FF_ADDR_WIDTH:0] DEPTH_C = (FF_ADDR_WIDTH+1)'(FF_DEPTH);
  localparam logic [FF_ADDR_WIDTH:0] NRD_C   = (FF_ADDR_WIDTH+1)'(NUM_RDATA);

  // Storage is deliberately not reset: the count gates every read, so an
  // unwritten location can never reach o_data.
  logic [DAT_WIDTH-1:0]           mem [FF_DEPTH];

  logic [FF_ADDR_WIDTH-1:0]       wr_ptr;
  logic [FF_ADDR_WIDTH-1:0]       rd_ptr;
  logic [FF_ADDR_WIDTH:0]         count;

  logic                           wr_acc;
  logic                           rd_acc;
  logic [FF_ADDR_WIDTH:0]         pop;
  logic [FF_ADDR_WIDTH:0]         count_next;
  logic [DAT_WIDTH*NUM_RDATA-1:0] window;

  // Acceptance uses the pre-edge count only, so a full buffer rejects a
  // write even when the same cycle pops entries (no bypass), and an entry
  // written this edge is invisible to a request sampled on the same edge.
  assign wr_acc = i_data_vld && (count < DEPTH_C);
  assign rd_acc = i_data_req && (count >= NRD_C);

  // Pop amount: stride clamped to the window size, zero when no read.
  always_comb begin
    pop = '0;
    if (rd_acc) begin
      pop = (i_stride > NRD_C) ? NRD_C : i_stride;
    end
  end

  assign count_next = count + {{FF_ADDR_WIDTH{1'b0}}, wr_acc} - pop;

  // Window taps: slot k reads entry rd_ptr+k, wrapping naturally through
  // the pointer width so windows straddling the last entry are seamless.
  generate
    for (genvar k = 0; k < NUM_RDATA; k++) begin : g_window
      localparam logic [FF_ADDR_WIDTH-1:0] OFFSET = FF_ADDR_WIDTH'(k);
      logic [FF_ADDR_WIDTH-1:0] addr;
      assign addr = rd_ptr + OFFSET;
      assign window[k*DAT_WIDTH +: DAT_WIDTH] = mem[addr];
    end
  endgenerate

  // Storage write port.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wr_ptr] <= i_data;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      rd_ptr <= rd_ptr + pop[FF_ADDR_WIDTH-1:0];
      count  <= count_next;
    end
  end

  // Window output register: loads on accepted read, otherwise holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_data     <= '0;
      o_data_vld <= 1'b0;
    end else begin
      o_data_vld <= rd_acc;
      if (rd_acc) begin
        o_data <= window;
      end
    end
  end

  // Sticky error flags: a set event in the same cycle beats the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_err_ovf <= 1'b0;
      o_err_udf <= 1'b0;
    end else begin
      if (i_data_vld && !wr_acc) begin
        o_err_ovf <= 1'b1;
      end else if (i_err_clr) begin
        o_err_ovf <= 1'b0;
      end
      if (i_data_req && !rd_acc) begin
        o_err_udf <= 1'b1;
      end else if (i_err_clr) begin
        o_err_udf <= 1'b0;
      end
    end
  end

  // Status is decoded from the registered count only.
  assign data_counter = count;
  assign o_empty      = (count == '0);
  assign o_full       = (count == DEPTH_C);
  assign o_rd_avail   = (count >= NRD_C);

endmodule
`default_nettype wire
